// File: rtl/inst_queue_pkg.sv
// rtl/inst_queue_pkg.sv - shared sizing constants for the fetch-to-decode instruction queue
//
// Purpose: default queue geometry and the width of one stored entry.
// Contents:
//   IQ_DEPTH       default number of queue entries (power of 2, >= 4)
//   IQ_ADDRW       log2(IQ_DEPTH)
//   GSH_BHR_WIDTH  branch history snapshot width
//   entry_width()  packed entry width {inst, pc, pred, predpc, bhr}
package inst_queue_pkg;

  localparam int IQ_DEPTH      = 8;
  localparam int IQ_ADDRW      = 3;
  localparam int GSH_BHR_WIDTH = 10;

  function automatic int entry_width(input int bhr_w);
    return 32 + 32 + 1 + 32 + bhr_w;
  endfunction

endpackage

// File: rtl/inst_queue_ram.sv
// rtl/inst_queue_ram.sv - instruction queue entry storage, 2 write / 2 async read ports
//
// Purpose: DEPTH x WIDTH register array holding queue entries. No reset on contents.
// Ports:
//   clk                    clock
//   we0/waddr0/wdata0      write port 0 (entry at tail)
//   we1/waddr1/wdata1      write port 1 (entry at tail+1)
//   raddr0/rdata0          async read port 0 (head)
//   raddr1/rdata1          async read port 1 (head+1)
module iq_entry_ram #(
  parameter int DEPTH = 8,
  parameter int ADDRW = 3,
  parameter int WIDTH = 107
) (
  input  logic             clk,
  input  logic             we0,
  input  logic [ADDRW-1:0] waddr0,
  input  logic [WIDTH-1:0] wdata0,
  input  logic             we1,
  input  logic [ADDRW-1:0] waddr1,
  input  logic [WIDTH-1:0] wdata1,
  input  logic [ADDRW-1:0] raddr0,
  output logic [WIDTH-1:0] rdata0,
  input  logic [ADDRW-1:0] raddr1,
  output logic [WIDTH-1:0] rdata1
);

  logic [WIDTH-1:0] mem [DEPTH];

  // The two write addresses are always tail and tail+1, so they never collide.
  always_ff @(posedge clk) begin
    if (we0) mem[waddr0] <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - fetch-to-decode instruction queue (2-in / 2-out circular FIFO)
//
// Purpose: buffers fetch groups of 1-2 instructions and presents up to two
// entries per cycle to decode in program order; flush drops everything.
// Ports:
//   i_clk, i_resetn                 clock, async active-low reset
//   flush                           branch mispredict, clears the queue
//   if_valid, if_pc, if_inst1/2,    incoming fetch group
//   if_invalid2, if_predict_cond,
//   if_predict_pc, if_bhr
//   if_stall                        queue cannot take a group this cycle
//   id_ready                        decode consumes all presented entries
//   id_valid1/2, id_inst1/2,        head and head+1 entries to decode
//   id_pc1/2, id_pred1/2,
//   id_predpc1/2, id_bhr1/2
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int ADDRW = IQ_ADDRW,
  parameter int BHR_W = GSH_BHR_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic             flush,
  input  logic             if_valid,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_inst1,
  input  logic [31:0]      if_inst2,
  input  logic             if_invalid2,
  input  logic             if_predict_cond,
  input  logic [31:0]      if_predict_pc,
  input  logic [BHR_W-1:0] if_bhr,
  output logic             if_stall,
  input  logic             id_ready,
  output logic             id_valid1,
  output logic             id_valid2,
  output logic [31:0]      id_inst1,
  output logic [31:0]      id_inst2,
  output logic [31:0]      id_pc1,
  output logic [31:0]      id_pc2,
  output logic             id_pred1,
  output logic             id_pred2,
  output logic [31:0]      id_predpc1,
  output logic [31:0]      id_predpc2,
  output logic [BHR_W-1:0] id_bhr1,
  output logic [BHR_W-1:0] id_bhr2
);

  localparam int ENTRY_W = entry_width(BHR_W);
  localparam logic [ADDRW:0] STALL_AT = (ADDRW+1)'(DEPTH - 2);
  localparam logic [ADDRW:0] CNT_TWO  = (ADDRW+1)'(2);
  localparam logic [ADDRW:0] CNT_MAX  = (ADDRW+1)'(DEPTH);

  logic [ADDRW-1:0]   head;
  logic [ADDRW-1:0]   tail;
  logic [ADDRW:0]     count;

  logic               push;
  logic [1:0]         push_n;
  logic [1:0]         pop_n;
  logic [31:0]        pred_pc_eff;
  logic [ENTRY_W-1:0] wdata0;
  logic [ENTRY_W-1:0] wdata1;
  logic [ENTRY_W-1:0] rdata0;
  logic [ENTRY_W-1:0] rdata1;

  // Stall looks only at the registered count, so a pop in the same cycle
  // never lets a group in; worst case a full pair must fit next cycle.
  assign if_stall  = (count > STALL_AT);
  assign id_valid1 = (count != '0);
  assign id_valid2 = (count >= CNT_TWO);

  assign push   = if_valid & ~if_stall & ~flush;
  assign push_n = push ? (if_invalid2 ? 2'd1 : 2'd2) : 2'd0;
  assign pop_n  = (id_ready & ~flush) ? ({1'b0, id_valid1} + {1'b0, id_valid2}) : 2'd0;

  // The prediction belongs to the last instruction of the group; the
  // stored target is zero whenever the entry is not predicted taken.
  assign pred_pc_eff = if_predict_cond ? if_predict_pc : 32'd0;

  always_comb begin
    wdata0 = '0;
    wdata1 = '0;
    if (if_invalid2) begin
      wdata0 = {if_inst1, if_pc, if_predict_cond, pred_pc_eff, if_bhr};
    end else begin
      wdata0 = {if_inst1, if_pc, 1'b0, 32'd0, if_bhr};
      wdata1 = {if_inst2, if_pc + 32'd4, if_predict_cond, pred_pc_eff, if_bhr};
    end
  end

  iq_entry_ram #(
    .DEPTH (DEPTH),
    .ADDRW (ADDRW),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk    (i_clk),
    .we0    (push),
    .waddr0 (tail),
    .wdata0 (wdata0),
    .we1    (push & ~if_invalid2),
    .waddr1 (tail + ADDRW'(1)),
    .wdata1 (wdata1),
    .raddr0 (head),
    .rdata0 (rdata0),
    .raddr1 (head + ADDRW'(1)),
    .rdata1 (rdata1)
  );

  // Invalid slots present all-zero data so decode never sees stale storage.
  always_comb begin
    {id_inst1, id_pc1, id_pred1, id_predpc1, id_bhr1} = id_valid1 ? rdata0 : '0;
    {id_inst2, id_pc2, id_pred2, id_predpc2, id_bhr2} = id_valid2 ? rdata1 : '0;
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + ADDRW'(pop_n);
      tail  <= tail + ADDRW'(push_n);
      count <= count + (ADDRW+1)'(push_n) - (ADDRW+1)'(pop_n);
    end
  end

  count_in_range: assert property (@(posedge i_clk) disable iff (!i_resetn) count <= CNT_MAX);

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - self-checking bench for inst_queue
module tb_inst_queue;

  localparam int DEPTH = 8;
  localparam int BHR_W = 10;

  logic             i_clk = 1'b0;
  logic             i_resetn;
  logic             flush;
  logic             if_valid;
  logic [31:0]      if_pc;
  logic [31:0]      if_inst1;
  logic [31:0]      if_inst2;
  logic             if_invalid2;
  logic             if_predict_cond;
  logic [31:0]      if_predict_pc;
  logic [BHR_W-1:0] if_bhr;
  logic             if_stall;
  logic             id_ready;
  logic             id_valid1, id_valid2;
  logic [31:0]      id_inst1, id_inst2, id_pc1, id_pc2;
  logic             id_pred1, id_pred2;
  logic [31:0]      id_predpc1, id_predpc2;
  logic [BHR_W-1:0] id_bhr1, id_bhr2;

  inst_queue dut (
    .i_clk           (i_clk),
    .i_resetn        (i_resetn),
    .flush           (flush),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_inst1        (if_inst1),
    .if_inst2        (if_inst2),
    .if_invalid2     (if_invalid2),
    .if_predict_cond (if_predict_cond),
    .if_predict_pc   (if_predict_pc),
    .if_bhr          (if_bhr),
    .if_stall        (if_stall),
    .id_ready        (id_ready),
    .id_valid1       (id_valid1),
    .id_valid2       (id_valid2),
    .id_inst1        (id_inst1),
    .id_inst2        (id_inst2),
    .id_pc1          (id_pc1),
    .id_pc2          (id_pc2),
    .id_pred1        (id_pred1),
    .id_pred2        (id_pred2),
    .id_predpc1      (id_predpc1),
    .id_predpc2      (id_predpc2),
    .id_bhr1         (id_bhr1),
    .id_bhr2         (id_bhr2)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0]      inst;
    logic [31:0]      pc;
    logic             pred;
    logic [31:0]      predpc;
    logic [BHR_W-1:0] bhr;
  } entry_t;

  entry_t model_q[$];

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst1;
    logic [31:0] inst2;
    logic        inv2;
    logic        pred;
    logic [31:0] predpc;
    logic [9:0]  bhr;
    logic        ready;
    logic        e_v1, e_v2;
    logic [31:0] e_pc1, e_pc2;
    logic        e_pred1, e_pred2;
    logic [31:0] e_ppc1, e_ppc2;
    logic [9:0]  e_bhr1;
    logic        e_stall;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, advance the reference model, then land on
  // the falling edge where outputs are sampled.
  task automatic step(input logic fl, input logic v, input logic [31:0] pc,
                      input logic [31:0] i1, input logic [31:0] i2, input logic inv2,
                      input logic pr, input logic [31:0] ppc, input logic [9:0] bhr,
                      input logic rdy);
    int n_pop;
    bit full;
    entry_t e;
    flush = fl; if_valid = v; if_pc = pc; if_inst1 = i1; if_inst2 = i2;
    if_invalid2 = inv2; if_predict_cond = pr; if_predict_pc = ppc; if_bhr = bhr;
    id_ready = rdy;
    full = (model_q.size() > DEPTH - 2);
    if (fl) begin
      model_q.delete();
    end else begin
      n_pop = rdy ? ((model_q.size() >= 2) ? 2 : model_q.size()) : 0;
      for (int k = 0; k < n_pop; k++) void'(model_q.pop_front());
      if (v && !full) begin
        if (inv2) begin
          e = '{i1, pc, pr, pr ? ppc : 32'd0, bhr};
          model_q.push_back(e);
        end else begin
          e = '{i1, pc, 1'b0, 32'd0, bhr};
          model_q.push_back(e);
          e = '{i2, pc + 32'd4, pr, pr ? ppc : 32'd0, bhr};
          model_q.push_back(e);
        end
      end
    end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 10'd0, rdy);
  endtask

  task automatic dual(input logic [31:0] pc, input logic rdy);
    step(1'b0, 1'b1, pc, pc ^ 32'hA5A5_0000, pc ^ 32'h5A5A_0000, 1'b0, 1'b0, 32'd0, pc[11:2], rdy);
  endtask

  task automatic cmp_model(input string tag);
    entry_t h0, h1;
    h0 = '{32'd0, 32'd0, 1'b0, 32'd0, '0};
    h1 = h0;
    if (model_q.size() >= 1) h0 = model_q[0];
    if (model_q.size() >= 2) h1 = model_q[1];
    chk({tag, "_count"}, 64'(dut.count), 64'(model_q.size()));
    chk({tag, "_stall"}, 64'(if_stall), 64'(model_q.size() > DEPTH - 2));
    chk({tag, "_v1"}, 64'(id_valid1), 64'(model_q.size() >= 1));
    chk({tag, "_v2"}, 64'(id_valid2), 64'(model_q.size() >= 2));
    chk({tag, "_slot1"}, {id_inst1, id_pc1}, {h0.inst, h0.pc});
    chk({tag, "_slot2"}, {id_inst2, id_pc2}, {h1.inst, h1.pc});
    chk({tag, "_pred"}, {31'd0, id_pred1, id_predpc1}, {31'd0, h0.pred, h0.predpc});
    chk({tag, "_pred2"}, {31'd0, id_pred2, id_predpc2}, {31'd0, h1.pred, h1.predpc});
    chk({tag, "_bhr"}, 64'({id_bhr1, id_bhr2}), 64'({h0.bhr, h1.bhr}));
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h100, 32'h0000_0013, 32'h0010_0093, 1'b0, 1'b0, 32'h0, 10'h3, 1'b0,
                1'b1, 1'b1, 32'h100, 32'h104, 1'b0, 1'b0, 32'h0, 32'h0, 10'h3, 1'b0};
    vecs[1] = '{1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 10'h0, 1'b1,
                1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 10'h0, 1'b0};
    vecs[2] = '{1'b1, 32'h300, 32'h0000_AAAA, 32'h0000_BBBB, 1'b1, 1'b1, 32'h200, 10'h155, 1'b0,
                1'b1, 1'b0, 32'h300, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, 10'h155, 1'b0};
    vecs[3] = '{1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 10'h0, 1'b1,
                1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 10'h0, 1'b0};
    vecs[4] = '{1'b1, 32'h400, 32'h1111_0000, 32'h2222_0000, 1'b0, 1'b1, 32'h500, 10'h2AA, 1'b0,
                1'b1, 1'b1, 32'h400, 32'h404, 1'b0, 1'b1, 32'h0, 32'h500, 10'h2AA, 1'b0};
    vecs[5] = '{1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 10'h0, 1'b1,
                1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 10'h0, 1'b0};

    i_resetn = 1'b0; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst1 = '0; if_inst2 = '0;
    if_invalid2 = 1'b0; if_predict_cond = 1'b0; if_predict_pc = '0; if_bhr = '0; id_ready = 1'b0;

    // Reset
    repeat (3) @(negedge i_clk);
    chk("rst_v1", 64'(id_valid1), 64'd0);
    chk("rst_v2", 64'(id_valid2), 64'd0);
    chk("rst_stall", 64'(if_stall), 64'd0);
    i_resetn = 1'b1;
    idle(1'b0);
    cmp_model("post_rst");

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      step(1'b0, vecs[i].valid, vecs[i].pc, vecs[i].inst1, vecs[i].inst2, vecs[i].inv2,
           vecs[i].pred, vecs[i].predpc, vecs[i].bhr, vecs[i].ready);
      chk($sformatf("vec%0d_v1", i), 64'(id_valid1), 64'(vecs[i].e_v1));
      chk($sformatf("vec%0d_v2", i), 64'(id_valid2), 64'(vecs[i].e_v2));
      chk($sformatf("vec%0d_pc1", i), 64'(id_pc1), 64'(vecs[i].e_pc1));
      chk($sformatf("vec%0d_pc2", i), 64'(id_pc2), 64'(vecs[i].e_pc2));
      chk($sformatf("vec%0d_pred1", i), 64'(id_pred1), 64'(vecs[i].e_pred1));
      chk($sformatf("vec%0d_pred2", i), 64'(id_pred2), 64'(vecs[i].e_pred2));
      chk($sformatf("vec%0d_ppc1", i), 64'(id_predpc1), 64'(vecs[i].e_ppc1));
      chk($sformatf("vec%0d_ppc2", i), 64'(id_predpc2), 64'(vecs[i].e_ppc2));
      chk($sformatf("vec%0d_bhr1", i), 64'(id_bhr1), 64'(vecs[i].e_bhr1));
      chk($sformatf("vec%0d_stall", i), 64'(if_stall), 64'(vecs[i].e_stall));
    end

    // Full: four pairs fill it, a fifth is dropped, one pop unstalls next cycle
    dual(32'h1000, 1'b0);
    dual(32'h1008, 1'b0);
    dual(32'h1010, 1'b0);
    chk("full_stall_at6", 64'(if_stall), 64'd0);
    dual(32'h1018, 1'b0);
    chk("full_count", 64'(dut.count), 64'd8);
    chk("full_stall", 64'(if_stall), 64'd1);
    dual(32'h1900, 1'b0);
    chk("full_ignored", 64'(dut.count), 64'd8);
    cmp_model("full");
    dual(32'h1A00, 1'b1);
    chk("full_pop_pc1", 64'(id_pc1), 64'h1008);
    chk("full_unstall", 64'(if_stall), 64'd0);
    cmp_model("full_pop");
    repeat (4) idle(1'b1);
    cmp_model("drained");

    // Random mix against the reference model
    for (int c = 0; c < 200; c++) begin
      logic [31:0] rpc;
      rpc = $urandom & 32'hFFFF_FFFC;
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), rpc, $urandom, $urandom,
           1'($urandom), 1'($urandom), $urandom, 10'($urandom), ($urandom_range(0, 2) != 0));
      cmp_model($sformatf("rnd%0d", c));
    end
    repeat (5) idle(1'b1);
    cmp_model("rnd_drain");

    // Flush with push and pop asserted alongside
    dual(32'h2000, 1'b0);
    dual(32'h2008, 1'b0);
    step(1'b0, 1'b1, 32'h2010, 32'h77, 32'h88, 1'b1, 1'b0, 32'h0, 10'h1, 1'b0);
    chk("flush_pre_count", 64'(dut.count), 64'd5);
    step(1'b1, 1'b1, 32'hDEAD0, 32'h99, 32'hAA, 1'b0, 1'b1, 32'h300, 10'h2, 1'b1);
    chk("flush_count", 64'(dut.count), 64'd0);
    chk("flush_v1", 64'(id_valid1), 64'd0);
    chk("flush_v2", 64'(id_valid2), 64'd0);
    idle(1'b0);
    chk("flush_no_ghost", 64'(id_valid1), 64'd0);
    cmp_model("flush");

    // Asynchronous reset mid-operation
    dual(32'h3000, 1'b0);
    dual(32'h3008, 1'b0);
    dual(32'h3010, 1'b0);
    chk("arst_pre_count", 64'(dut.count), 64'd6);
    #1 i_resetn = 1'b0;
    #1;
    chk("arst_v1", 64'(id_valid1), 64'd0);
    chk("arst_v2", 64'(id_valid2), 64'd0);
    chk("arst_count", 64'(dut.count), 64'd0);
    model_q.delete();
    @(negedge i_clk);
    i_resetn = 1'b1;
    dual(32'h4000, 1'b0);
    cmp_model("after_arst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
